// File: rtl/cbx_param.sv
// cbx_param: x-channel connection block with pass-through tracks, NUM_IPIN tapped muxes and a
// double-buffered configuration chain (shadow shift register, commit into active selects).
// Optional build macro: CBX_PARAM_CFG_PARITY_EN appends an even-parity bit to the chain.
module cbx_param #(
  parameter int CHAN_WIDTH = 30,
  parameter int NUM_IPIN   = 4,
  parameter int MUX_SIZE   = 12,
  parameter int TAP_STRIDE = 3
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic [CHAN_WIDTH-1:0] chanx_left_in,
  input  logic [CHAN_WIDTH-1:0] chanx_right_in,
  output logic [CHAN_WIDTH-1:0] chanx_left_out,
  output logic [CHAN_WIDTH-1:0] chanx_right_out,
  output logic [NUM_IPIN-1:0]   ipin_out,
  input  logic                  ccff_head,
  input  logic                  ccff_en,
  input  logic                  ccff_commit,
  output logic                  ccff_tail,
  output logic                  cfg_done,
  output logic                  cfg_err
);

  localparam int S        = $clog2(MUX_SIZE);
  localparam int SEL_BITS = NUM_IPIN * S;
`ifdef CBX_PARAM_CFG_PARITY_EN
  localparam int TOTAL    = SEL_BITS + 1;
`else
  localparam int TOTAL    = SEL_BITS;
`endif
  localparam int CNT_W    = $clog2(TOTAL + 2);
  localparam int HALF     = MUX_SIZE / 2;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TOTAL + 1);
  localparam logic [S:0]       MUX_LIM  = (S + 1)'(MUX_SIZE);

  logic [TOTAL-1:0]    r_shadow;
  logic [SEL_BITS-1:0] r_active;
  logic [CNT_W-1:0]    r_count;
  logic                r_done;
  logic                r_err;
  logic                w_commit_ok;
  logic [NUM_IPIN-1:0] w_ipin;

`ifdef CBX_PARAM_CFG_PARITY_EN
  function automatic logic parity_even(input logic [TOTAL-1:0] v);
    return ~(^v);
  endfunction
`endif

  // Commit is accepted only on an exact-length load (and good parity when enabled)
  always_comb begin
`ifdef CBX_PARAM_CFG_PARITY_EN
    w_commit_ok = (r_count == CNT_FULL) && parity_even(r_shadow);
`else
    w_commit_ok = (r_count == CNT_FULL);
`endif
  end

  // Shadow chain, bit counter, active selects and status flags; commit has priority over shift
  always_ff @(posedge prog_clk) begin
    if (!prog_reset) begin
      r_shadow <= '0;
      r_active <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else if (ccff_commit) begin
      if (w_commit_ok) begin
        r_active <= r_shadow[SEL_BITS-1:0];
        r_done   <= 1'b1;
        r_err    <= 1'b0;
      end else begin
        r_done   <= 1'b0;
        r_err    <= 1'b1;
      end
      r_count <= '0;
    end else if (ccff_en) begin
      r_shadow <= {r_shadow[TOTAL-2:0], ccff_head};
      if (r_count != CNT_SAT) begin
        r_count <= r_count + CNT_W'(1);
      end
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end
  end

  // Tap wiring is fixed at elaboration; only the select index is dynamic
  for (genvar k = 0; k < NUM_IPIN; k++) begin : g_ipin
    logic [MUX_SIZE-1:0] w_in;
    logic [S-1:0]        w_sel;

    for (genvar j = 0; j < HALF; j++) begin : g_tap
      localparam int T = (k + j * TAP_STRIDE) % CHAN_WIDTH;
      assign w_in[2*j]   = chanx_left_in[T];
      assign w_in[2*j+1] = chanx_right_in[T];
    end

    assign w_sel     = r_active[k*S +: S];
    assign w_ipin[k] = ({1'b0, w_sel} < MUX_LIM) ? w_in[w_sel] : 1'b0;
  end

  assign chanx_right_out = chanx_left_in;
  assign chanx_left_out  = chanx_right_in;
  assign ipin_out        = w_ipin;
  assign ccff_tail       = r_shadow[TOTAL-1];
  assign cfg_done        = r_done;
  assign cfg_err         = r_err;

endmodule

// File: tb/tb_cbx_param.sv
// Randomised bench for cbx_param against a queue-based model of the configuration chain
// and an arithmetic model of the mux taps; build with CBX_PARAM_CFG_PARITY_EN to cover parity.
module tb_cbx_param;
  localparam int CW = 30, NI = 4, MS = 12, TS = 3, S = 4, SEL_BITS = NI * S;
`ifdef CBX_PARAM_CFG_PARITY_EN
  localparam int TOTAL = SEL_BITS + 1;
`else
  localparam int TOTAL = SEL_BITS;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] l_in = '0, r_in = '0;
  logic          head = 1'b0, en = 1'b0, commit = 1'b0;
  logic [CW-1:0] l_out, r_out;
  logic [NI-1:0] ipin;
  logic          tail, done, err;

  cbx_param dut (
    .prog_clk(clk), .prog_reset(rst_n),
    .chanx_left_in(l_in), .chanx_right_in(r_in),
    .chanx_left_out(l_out), .chanx_right_out(r_out),
    .ipin_out(ipin),
    .ccff_head(head), .ccff_en(en), .ccff_commit(commit),
    .ccff_tail(tail), .cfg_done(done), .cfg_err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: history of shifted bits (newest at back), count since last commit, active selects.
  bit                  hist[$];
  int                  m_count = 0;
  logic [SEL_BITS-1:0] m_active = '0;
  bit                  m_done = 1'b0, m_err = 1'b0;

  function automatic bit shadow_bit(int i);
    if (i < hist.size()) return hist[hist.size() - 1 - i];
    return 1'b0;
  endfunction

  function automatic bit exp_ipin(int k);
    int sel, t;
    sel = int'(m_active[k*S +: S]);
    if (sel >= MS) return 1'b0;
    t = (k + (sel / 2) * TS) % CW;
    return (sel % 2 == 0) ? l_in[t] : r_in[t];
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit c, input bit h);
    bit ok;
    if (!r) begin
      hist.delete();
      m_count = 0; m_active = '0; m_done = 1'b0; m_err = 1'b0;
    end else if (c) begin
      ok = (m_count == TOTAL);
`ifdef CBX_PARAM_CFG_PARITY_EN
      begin
        int ones;
        ones = 0;
        for (int i = 0; i < TOTAL; i++) ones += int'(shadow_bit(i));
        ok = ok && (ones % 2 == 0);
      end
`endif
      if (ok) begin
        for (int i = 0; i < SEL_BITS; i++) m_active[i] = shadow_bit(i);
        m_done = 1'b1; m_err = 1'b0;
      end else begin
        m_done = 1'b0; m_err = 1'b1;
      end
      m_count = 0;
    end else if (e) begin
      hist.push_back(h);
      if (hist.size() > TOTAL) void'(hist.pop_front());
      if (m_count < TOTAL + 1) m_count++;
      m_done = 1'b0; m_err = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [NI-1:0] e_ipin;
    for (int k = 0; k < NI; k++) e_ipin[k] = exp_ipin(k);
    chk("chanx_right_out", 64'(r_out), 64'(l_in));
    chk("chanx_left_out", 64'(l_out), 64'(r_in));
    chk("ipin_out", 64'(ipin), 64'(e_ipin));
    chk("ccff_tail", 64'(tail), 64'(shadow_bit(TOTAL - 1)));
    chk("cfg_done", 64'(done), 64'(m_done));
    chk("cfg_err", 64'(err), 64'(m_err));
  endtask

  // One prog_clk cycle: apply controls, advance model on the edge, new channel data, compare.
  task automatic step(input bit r, input bit e, input bit c, input bit h);
    rst_n = r; en = e; commit = c; head = h;
    @(posedge clk);
    model_edge(r, e, c, h);
    @(negedge clk);
    l_in = CW'($urandom());
    r_in = CW'($urandom());
    #1 compare();
  endtask

  function automatic logic [TOTAL-1:0] mk(input logic [SEL_BITS-1:0] sel_bits);
    logic [TOTAL-1:0] v;
    v = '0;
    v[SEL_BITS-1:0] = sel_bits;
`ifdef CBX_PARAM_CFG_PARITY_EN
    v[TOTAL-1] = ^sel_bits;
`endif
    return v;
  endfunction

  task automatic shift_vec(input logic [TOTAL-1:0] v);
    for (int i = TOTAL - 1; i >= 0; i--) step(1'b1, 1'b1, 1'b0, v[i]);
  endtask

  task automatic shift_rand(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'($urandom()));
  endtask

  logic [TOTAL-1:0] v;

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_tail", 64'(tail), 64'd0);
    chk("reset_ipin_left", 64'(ipin), 64'(l_in[NI-1:0]));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // ipin0 select 5 -> chanx_right_in[6]
    v = mk(16'h0005);
    shift_vec(v);
    chk("tail_first_bit", 64'(tail), 64'(v[TOTAL-1]));
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("sel5_done", 64'(done), 64'd1);
    chk("sel5_ipin0", 64'(ipin[0]), 64'(r_in[6]));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("sel5_ipin0_later", 64'(ipin[0]), 64'(r_in[6]));

    // repeated commit sees count 0
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("recommit_err", 64'(err), 64'd1);
    chk("recommit_hold", 64'(ipin[0]), 64'(r_in[6]));

    // short and overrun loads are rejected
    shift_rand(TOTAL - 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("short_err", 64'(err), 64'd1);
    chk("short_hold", 64'(ipin[0]), 64'(r_in[6]));
    shift_rand(20);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("overrun_err", 64'(err), 64'd1);
    chk("overrun_hold", 64'(ipin[0]), 64'(r_in[6]));

    // out-of-range select on ipin2
    shift_vec(mk(16'h0D00));
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("sel13_done", 64'(done), 64'd1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("sel13_ipin2", 64'(ipin[2]), 64'd0);
    end

    // shift and commit together: commit wins, no shift
    v = mk(16'h1234);
    shift_vec(v);
    step(1'b1, 1'b1, 1'b1, ~v[TOTAL-2]);
    chk("encommit_done", 64'(done), 64'd1);
    chk("encommit_tail", 64'(tail), 64'(v[TOTAL-1]));
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("encommit_count0", 64'(err), 64'd1);

`ifdef CBX_PARAM_CFG_PARITY_EN
    v = mk(16'h0007);
    v[TOTAL-1] = ~v[TOTAL-1];
    shift_vec(v);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("parity_err", 64'(err), 64'd1);
`endif

    // reset mid-shift after a good commit
    shift_vec(mk(16'h3579));
    step(1'b1, 1'b0, 1'b1, 1'b0);
    shift_rand(5);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_err", 64'(err), 64'd0);
    chk("midreset_tail", 64'(tail), 64'd0);
    chk("midreset_ipin", 64'(ipin), 64'(l_in[NI-1:0]));

    // randomised traffic with periodic full loads
    for (int it = 0; it < 600; it++) begin
      if (it % 60 == 0) begin
        shift_vec(mk(SEL_BITS'($urandom())));
        step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom()));
      end else begin
        step($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 60,
             $urandom_range(0, 99) < 6, 1'($urandom()));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cbx_param.md
# cbx_param

Parametrised x-channel connection block with a double-buffered configuration chain. Channel tracks pass straight through, left to right and right to left. Each of NUM_IPIN grid input pins is driven by a MUX_SIZE:1 selector over left/right channel tracks. Configuration bits are shifted into a shadow chain on prog_clk. A bit counter validates the load, and the bits are applied atomically to the active mux selects only on an explicit commit. The block sits between the switch blocks and the bottom/top grid I/O tiles, in the same configuration chain as the existing connection blocks.

## Interface
- CHAN_WIDTH, 30, tracks per direction
- NUM_IPIN, 4, grid input pins driven
- MUX_SIZE, 12, inputs per ipin mux; must be even and ≤ 2·CHAN_WIDTH
- TAP_STRIDE, 3, track spacing between consecutive mux taps
- Derived: S = clog2(MUX_SIZE) select bits per ipin; TOTAL = NUM_IPIN·S (+1 with parity, see Configuration)

Ports:
- prog_clk  in  1  configuration clock
- prog_reset  in  1  reset, synchronous to prog_clk, active-low
- chanx_left_in  in  CHAN_WIDTH  tracks entering from left
- chanx_right_in  in  CHAN_WIDTH  tracks entering from right
- chanx_left_out  out  CHAN_WIDTH  tracks leaving left
- chanx_right_out  out  CHAN_WIDTH  tracks leaving right
- ipin_out  out  NUM_IPIN  grid input pin drives
- ccff_head  in  1  serial configuration data in
- ccff_en  in  1  shift enable
- ccff_commit  in  1  single-cycle pulse: apply shadow to active
- ccff_tail  out  1  serial configuration data out, to the next block
- cfg_done  out  1  last commit succeeded
- cfg_err  out  1  last commit rejected

## Operation
- Pass-through is combinational: chanx_right_out[i] = chanx_left_in[i] and chanx_left_out[i] = chanx_right_in[i].
- Mux taps: for ipin k and tap j in 0..MUX_SIZE/2-1, t = (k + j·TAP_STRIDE) mod CHAN_WIDTH.
  - Input 2j = chanx_left_in[t].
  - Input 2j+1 = chanx_right_in[t].
- Select for ipin k = active[k·S +: S], LSB at the lower index.
  - ipin_out[k] = input[select] when select < MUX_SIZE.
  - A select ≥ MUX_SIZE drives 0.
- Shift: while ccff_en=1, shadow[0] ← ccff_head and shadow[i] ← shadow[i-1]. ccff_tail = shadow[TOTAL-1].
- Bit counter, width clog2(TOTAL+2):
  - Increments per shift.
  - Saturates at TOTAL+1, which marks overrun. It does not wrap.
- Commit, on a ccff_commit pulse:
  - If count == TOTAL (and parity passes when enabled): active ← shadow, cfg_done=1, cfg_err=0.
  - Otherwise: active is unchanged, cfg_done=0, cfg_err=1.
  - In both cases the count resets to 0.
- Any shift cycle clears cfg_done and cfg_err.
- ccff_commit and ccff_en in the same cycle: the commit is evaluated on the pre-edge shadow and count, and the shift is dropped for that cycle.

## Timing
- Reset, with prog_reset=0 at a prog_clk edge, clears:
  - shadow and active to 0
  - count to 0
  - cfg_done, cfg_err and ccff_tail to 0
- Since active resets to 0, every ipin_out = chanx_left_in[k] after reset.
- A reset in mid-shift or coincident with a commit wins and clears everything, including active.
- Shift latency: the bit presented at edge n appears on ccff_tail after TOTAL edges, i.e. TOTAL cycles of head-to-tail delay.
- Commit: active, cfg_done and cfg_err update on the commit edge. ipin_out reflects the new selects combinationally in the following cycle.
- Pass-through and mux paths have no register; ipin_out glitches only on an active update.
- ccff_commit held high for more than one cycle counts as repeated commits. The second commit sees count=0 and rejects with cfg_err=1; active holds the first commit's value.

## Configuration
- CBX_PARAM_CFG_PARITY_EN defined:
  - The chain carries one extra bit at shadow[TOTAL-1], and TOTAL includes it.
  - The commit additionally requires even parity across all TOTAL shadow bits; a parity failure gives cfg_err=1 and leaves active unchanged.
  - The parity bit never drives a select.
- CBX_PARAM_CFG_PARITY_EN undefined: TOTAL = NUM_IPIN·S, with no parity check.

## Test plan
All scenarios use default parameters: S=4, TOTAL=16 (17 with parity).
- Reset then drive random tracks -> chanx_*_out mirror the opposite inputs every cycle; ipin_out[k] = chanx_left_in[k]; cfg_done=cfg_err=0.
- Shift 16 bits that give ipin0 select=5, then commit -> cfg_done=1; ipin_out[0] follows chanx_right_in[6] on the next cycle.
- Shift 15 bits then commit -> cfg_err=1 and active unchanged. Shift 20 bits then commit -> cfg_err=1, proving saturation with no wrap.
- Commit with select=13 on ipin2 -> ipin_out[2] = 0 for any channel data. ccff_tail reproduces the head stream delayed by 16 cycles.
- ccff_en and ccff_commit asserted together at count=16 -> commit succeeds, shadow is not shifted, count=0.
- Assert prog_reset=0 mid-shift after a prior successful commit -> active, count and flags are all 0 on the next edge. With CBX_PARAM_CFG_PARITY_EN, 17 bits with odd parity -> cfg_err=1.
